// File: rtl/weight_writer.sv
// weight_writer: collects an N x N weight tile streamed in row-major order,
// then writes it to weight memory transposed (column-major) starting at a
// latched base address. Addresses wrap modulo 2^ADDR_W.
//
// Input handshake: a weight is transferred on a rising clk edge where both
// in_valid and in_ready are 1. in_ready is high only while loading. The
// source may hold in_valid low for any number of cycles. Nothing is consumed
// while in_ready is low.
module weight_writer #(
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam int NN    = N * N;
    localparam int CW    = $clog2(NN + 1);  // counts 0..NN
    localparam int IDX_W = $clog2(NN);      // buffer slot index
    localparam int IW    = $clog2(N);       // row / column index
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CW-1:0]     cnt_q;      // load index in LOAD, write index k in WRITE
    logic [IW-1:0]     k_lo_q;     // k mod N
    logic [IW-1:0]     k_hi_q;     // k div N
    logic [DATA_W-1:0] buf_q [DEPTH];
    logic              accept;
    logic [IDX_W-1:0]  rd_idx;

    assign accept    = in_valid && in_ready;
    assign dbg_state = state_q;

    // Transposed read: write k takes row-major slot (k mod N)*N + (k div N).
    assign rd_idx = IDX_W'(k_lo_q) * IDX_W'(N) + IDX_W'(k_hi_q);

    // Tile buffer: stores accepted weight j in slot j; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[cnt_q[IDX_W-1:0]] <= in_data;
        end
    end

    // Control FSM with registered outputs. WRITE lasts NN+1 cycles: the first
    // registers write 0, the last presents write NN-1 while preparing done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            cnt_q     <= '0;
            k_lo_q    <= '0;
            k_hi_q    <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        cnt_q    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (cnt_q == CW'(NN - 1)) begin
                            cnt_q    <= '0;
                            k_lo_q   <= '0;
                            k_hi_q   <= '0;
                            in_ready <= 1'b0;
                            state_q  <= S_WRITE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (cnt_q == CW'(NN)) begin
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_waddr <= base_q + ADDR_W'(cnt_q);
                        mem_wdata <= buf_q[rd_idx];
                        cnt_q     <= cnt_q + 1'b1;
                        if (k_lo_q == IW'(N - 1)) begin
                            k_lo_q <= '0;
                            k_hi_q <= k_hi_q + 1'b1;
                        end else begin
                            k_lo_q <= k_lo_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    cnt_q   <= '0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/weight_writer.md
WEIGHT_WRITER -- requirements
Module: weight_writer

Interface
REQ-001 SHALL have parameter N, default 2, meaning matrix dimension (tile holds N*N weights); legal values 2..4.
REQ-002 SHALL have parameter DATA_W, default 16, meaning weight width in bits.
REQ-003 SHALL have parameter ADDR_W, default 13, meaning weight-memory address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin loading a tile.
REQ-007 SHALL have port base_addr  input  ADDR_W  destination start address, sampled with start.
REQ-008 SHALL have port in_valid  input  1  in_data holds a weight.
REQ-009 SHALL have port in_data  input  DATA_W  weight, supplied in row-major order.
REQ-010 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-011 SHALL have port mem_we  output  1  write strobe to weight memory.
REQ-012 SHALL have port mem_waddr  output  ADDR_W  write address.
REQ-013 SHALL have port mem_wdata  output  DATA_W  write data.
REQ-014 SHALL have port busy  output  1  high from accepted start until return to IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the last write has been issued.

Function
REQ-016 SHALL implement states IDLE, LOAD, WRITE, DONE.
REQ-017 In IDLE, start=1 SHALL latch base_addr, clear the element counter, and move to LOAD next cycle.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 in_ready SHALL be 1 only in LOAD; a weight is accepted only when in_valid and in_ready are both 1 on a rising edge.
REQ-020 Accepted weight number j (0..N*N-1) SHALL be stored in buffer slot j; in_valid=0 stalls LOAD indefinitely with no state change.
REQ-021 Acceptance of weight N*N-1 SHALL move to WRITE on the following cycle; in_ready SHALL be 0 from that cycle on.
REQ-022 In WRITE, for k = 0..N*N-1 on consecutive cycles, SHALL drive mem_we=1, mem_waddr = (base+k) mod 2^ADDR_W, mem_wdata = buffer[(k mod N)*N + (k div N)] (transpose of the row-major input).
REQ-023 mem_we, mem_waddr, mem_wdata SHALL be registered outputs; mem_we SHALL be 0 in all states except WRITE.
REQ-024 After write k=N*N-1, SHALL enter DONE for exactly one cycle with done=1, then return to IDLE.
REQ-025 busy SHALL be 1 in LOAD, WRITE and DONE, 0 in IDLE.
REQ-026 Latency: last weight accepted at edge T -> first write valid after edge T+1; last write after edge T+N*N; done after edge T+N*N+1.
REQ-027 Address arithmetic SHALL wrap modulo 2^ADDR_W with no error indication (e.g. base 0x1FFF, N=2 -> 0x1FFF, 0x0000, 0x0001, 0x0002).
REQ-028 start asserted in the same cycle as done SHALL be ignored; start is honoured from the IDLE cycle onward.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE and in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0, counters 0.
REQ-030 Reset asserted mid-LOAD or mid-WRITE SHALL abort the tile; no further writes SHALL be issued after reset deasserts until a new start.
REQ-031 Buffer contents need not be cleared by reset.

Verification
REQ-032 N=2, start with base_addr=0x000F, stream 3,4,5,6 back-to-back -> writes (0x000F,3), (0x0010,5), (0x0011,4), (0x0012,6) on 4 consecutive cycles, then done=1 for one cycle, busy=0 next.
REQ-033 Same stream with in_valid toggled 1,0,0,1,1,0,1 -> identical write sequence; in_ready stays 1 throughout LOAD and no extra weight is consumed.
REQ-034 base_addr=0x1FFE, N=2, weights 1,2,3,4 -> writes (0x1FFE,1), (0x1FFF,3), (0x0000,2), (0x0001,4).
REQ-035 start pulsed during LOAD with base_addr=0x0100 -> ignored; writes still target the originally latched base.
REQ-036 reset=0 asynchronously after second WRITE cycle -> mem_we drops without a clock edge, no remaining writes, busy=0; new start with base 0x0020 completes normally.
REQ-037 N=3, base 0x0000, weights 1..9 -> write data sequence 1,4,7,2,5,8,3,6,9 at addresses 0..8.
